// File: rtl/ff_reg_arbiter_if.sv
// ff_reg_arbiter_if: req/gnt/ack handshake and register-status bundle; master = requesters, slave = arbiter
interface ff_reg_arbiter_if #(parameter int NREQ = 4, parameter int WIDTH = 8);
  logic [NREQ-1:0] req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] ack;
  logic [WIDTH-1:0] q;
  logic busy;
  logic [7:0] wcount;
  modport master(output req, wdata, input gnt, ack, q, busy, wcount);
  modport slave(input req, wdata, output gnt, ack, q, busy, wcount);
endinterface

// File: rtl/ff_reg_arbiter.sv
// ff_reg_arbiter: round-robin (or fixed-priority with FF_ARB_FIXED_PRIO_EN) write arbiter for a shared register; ports clk, rst (async active-low), bus (slave: req/wdata in, gnt/ack/q/busy/wcount out)
module ff_reg_arbiter #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  ff_reg_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
`ifdef FF_ARB_FIXED_PRIO_EN
  localparam bit RR = 1'b0;
`else
  localparam bit RR = 1'b1;
`endif
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] ptr, ptr_nx, gi, gi_nx, sel, base, g_inc;
  logic [NREQ-1:0] gnt, gnt_nx, ack, ack_nx;
  logic [WIDTH-1:0] q, q_nx;
  logic [7:0] cnt, cnt_nx;
  assign base = RR ? ptr : '0;
  assign g_inc = (gi == IW'(NREQ - 1)) ? '0 : gi + IW'(1);
  // descending scan so the lowest offset from base wins
  always_comb begin
    sel = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (bus.req[(int'(base) + i) % NREQ]) sel = IW'((int'(base) + i) % NREQ);
  end
  always_comb begin
    state_nx = state;
    ptr_nx = ptr;
    gi_nx = gi;
    gnt_nx = gnt;
    ack_nx = '0;
    q_nx = q;
    cnt_nx = cnt;
    if (state == IDLE && |bus.req) begin
      gi_nx = sel;
      gnt_nx = NREQ'(1) << sel;
      state_nx = GRANT;
    end else if (state == GRANT && bus.req[gi]) begin
      q_nx = bus.wdata[gi*WIDTH +: WIDTH];
      ack_nx = gnt;
      cnt_nx = cnt + 8'd1;
      state_nx = RELEASE;
    end else if (state != IDLE && !bus.req[gi]) begin
      gnt_nx = '0;
      ptr_nx = RR ? g_inc : ptr;
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr <= '0;
      gi <= '0;
      gnt <= '0;
      ack <= '0;
      q <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      gi <= gi_nx;
      gnt <= gnt_nx;
      ack <= ack_nx;
      q <= q_nx;
      cnt <= cnt_nx;
    end
  end
  assign bus.gnt = gnt;
  assign bus.ack = ack;
  assign bus.q = q;
  assign bus.wcount = cnt;
  assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_ff_reg_arbiter.sv
// tb_ff_reg_arbiter: directed and random checks of ff_reg_arbiter against a transaction-level model
module tb_ff_reg_arbiter;
  localparam int N = 4;
`ifdef FF_ARB_FIXED_PRIO_EN
  localparam bit RR = 1'b0;
`else
  localparam bit RR = 1'b1;
`endif
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  ff_reg_arbiter_if #(.NREQ(N), .WIDTH(8)) bus();
  ff_reg_arbiter #(.NREQ(N), .WIDTH(8)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic int pick(input logic [N-1:0] r, input int base);
    for (int k = 0; k < N; k++)
      if (r[(base + k) % N]) return (base + k) % N;
    return -1;
  endfunction
  // model: owner of the register (-1 none), whether its write has happened
  int m_owner, m_ptr;
  bit m_wr;
  logic [7:0] m_q, m_cnt;
  logic [N-1:0] m_ack;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner <= -1;
      m_wr <= 1'b0;
      m_ptr <= 0;
      m_q <= '0;
      m_cnt <= '0;
      m_ack <= '0;
    end else begin
      m_ack <= '0;
      if (m_owner < 0) begin
        if (bus.req != 0) begin
          m_owner <= pick(bus.req, RR ? m_ptr : 0);
          m_wr <= 1'b0;
        end
      end else if (!m_wr && bus.req[m_owner]) begin
        m_q <= bus.wdata[m_owner*8 +: 8];
        m_ack <= N'(1 << m_owner);
        m_cnt <= m_cnt + 8'd1;
        m_wr <= 1'b1;
      end else if (!bus.req[m_owner]) begin
        if (RR) m_ptr <= (m_owner + 1) % N;
        m_owner <= -1;
      end
    end
  end
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("gnt", bus.gnt, m_owner < 0 ? 0 : 32'(1 << m_owner));
      chk("ack", bus.ack, m_ack);
      chk("q", bus.q, m_q);
      chk("wcount", bus.wcount, m_cnt);
      chk("busy", bus.busy, m_owner >= 0);
    end
  end
  task automatic wait_gnt;
    for (int w = 0; w < 20 && bus.gnt == 0; w++) @(negedge clk);
  endtask
  task automatic wait_ack;
    for (int w = 0; w < 20 && bus.ack == 0; w++) @(negedge clk);
  endtask
  task automatic do_write(input int i, input logic [7:0] d);
    bus.wdata[i*8 +: 8] = d;
    bus.req[i] = 1'b1;
    wait_gnt();
    wait_ack();
    chk("wr_ack", bus.ack, 32'(1 << i));
    bus.req[i] = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    logic [7:0] last;
    logic [N-1:0] done;
    rst = 1'b0;
    bus.req = '0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wcount", bus.wcount, 0);
    rst = 1'b1;
    @(negedge clk);
    bus.wdata[16 +: 8] = 8'hA5;
    bus.req = 4'b0100;
    step();
    chk("single_gnt", bus.gnt, 4'b0100);
    chk("single_busy", bus.busy, 1);
    step();
    chk("single_q", bus.q, 8'hA5);
    chk("single_ack", bus.ack, 4'b0100);
    chk("single_wcount", bus.wcount, 1);
    step();
    chk("single_ack_off", bus.ack, 0);
    chk("single_gnt_hold", bus.gnt, 4'b0100);
    @(negedge clk);
    bus.req[2] = 1'b0;
    step();
    chk("single_gnt_drop", bus.gnt, 0);
    chk("single_idle", bus.busy, 0);
    @(negedge clk);
    bus.req[3] = 1'b1;
    step();
    chk("abort_gnt", bus.gnt, 4'b1000);
    @(negedge clk);
    bus.req[3] = 1'b0;
    step();
    chk("abort_gnt_clr", bus.gnt, 0);
    chk("abort_ack", bus.ack, 0);
    chk("abort_q", bus.q, 8'hA5);
    chk("abort_wcount", bus.wcount, 1);
    @(negedge clk);
    bus.wdata[24 +: 8] = 8'h3C;
    bus.req = 4'b1010;
    step();
    chk("abort_next_from0", bus.gnt, 4'b0010);
    step();
    @(negedge clk);
    bus.req[1] = 1'b0;
    step();
    step();
    chk("pending_gnt3", bus.gnt, 4'b1000);
    step();
    chk("pending_q3", bus.q, 8'h3C);
    @(negedge clk);
    bus.req[3] = 1'b0;
    step();
    @(negedge clk);
    bus.wdata[8 +: 8] = 8'h5A;
    bus.req = 4'b0010;
    step();
    chk("rstmid_gnt", bus.gnt, 4'b0010);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_gnt0", bus.gnt, 0);
    chk("rstmid_ack0", bus.ack, 0);
    chk("rstmid_q0", bus.q, 0);
    chk("rstmid_wcount0", bus.wcount, 0);
    chk("rstmid_busy0", bus.busy, 0);
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    chk("rstmid_nowrite", bus.wcount, 0);
    chk("rstmid_idle", bus.busy, 0);
    @(negedge clk);
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int g;
      g = RR ? n % N : 0;
      wait_gnt();
      chk("rr_order", bus.gnt, 32'(1 << g));
      wait_ack();
      chk("rr_ack", bus.ack, 32'(1 << g));
      bus.req[g] = 1'b0;
      @(negedge clk);
      chk("rr_release", bus.gnt, 0);
      bus.req[g] = 1'b1;
    end
    bus.req = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    last = '0;
    for (int n = 0; n < 256; n++) begin
      last = 8'($urandom);
      do_write(n % N, last);
      if (n == 254) chk("wrap_255", bus.wcount, 8'hFF);
    end
    chk("wrap_0", bus.wcount, 8'h00);
    chk("wrap_q", bus.q, last);
    done = '0;
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] r;
      @(negedge clk);
      rst = (c % 700 == 350) ? 1'b0 : 1'b1;
      r = bus.req;
      for (int i = 0; i < N; i++) begin
        if (bus.ack[i]) done[i] = 1'b1;
        if (r[i] && done[i]) begin
          if ($urandom_range(1, 0) == 1) begin
            r[i] = 1'b0;
            done[i] = 1'b0;
          end
        end else if (r[i] && bus.gnt[i]) begin
          if ($urandom_range(7, 0) == 0) r[i] = 1'b0;
        end else if (!r[i] && $urandom_range(2, 0) == 0) begin
          r[i] = 1'b1;
          done[i] = 1'b0;
          bus.wdata[i*8 +: 8] = 8'($urandom);
        end
      end
      bus.req = r;
    end
    rst = 1'b1;
    bus.req = '0;
    repeat (6) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
